// File: rtl/llc_stats.sv
// LLC access statistics: saturating read/write/hit/miss counters plus an optional
// hit-ratio divider, compiled in only when LLC_STATS_RATIO_EN is defined.
module llc_stats #(
    parameter int CNT_W   = 32,
    parameter int CMDSIZE = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               acc_valid,
    input  logic [CMDSIZE-1:0] acc_cmd,
    input  logic               acc_hit,
    input  logic               clr,
    input  logic               ratio_req,
    output logic [CNT_W-1:0]   reads,
    output logic [CNT_W-1:0]   writes,
    output logic [CNT_W-1:0]   hits,
    output logic [CNT_W-1:0]   misses,
    output logic               sat,
    output logic               ratio_busy,
    output logic               ratio_valid,
    output logic [13:0]        ratio_pct
);

    logic is_rd;
    logic is_wr;
    logic is_acc;
    logic inc_rd;
    logic inc_wr;
    logic inc_hit;
    logic inc_miss;
    logic hit_sat;

    // Only commands 0..2 are real data accesses; everything else is trace noise.
    always_comb begin
        is_rd    = (acc_cmd == CMDSIZE'(0)) || (acc_cmd == CMDSIZE'(2));
        is_wr    = (acc_cmd == CMDSIZE'(1));
        is_acc   = acc_valid && !clr && (is_rd || is_wr);
        inc_rd   = is_acc && is_rd;
        inc_wr   = is_acc && is_wr;
        inc_hit  = is_acc && acc_hit;
        inc_miss = is_acc && !acc_hit;
        hit_sat  = (inc_rd && (&reads)) || (inc_wr && (&writes)) ||
                   (inc_hit && (&hits)) || (inc_miss && (&misses));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reads  <= '0;
            writes <= '0;
            hits   <= '0;
            misses <= '0;
            sat    <= 1'b0;
        end else if (clr) begin
            reads  <= '0;
            writes <= '0;
            hits   <= '0;
            misses <= '0;
            sat    <= 1'b0;
        end else begin
            if (inc_rd && !(&reads))
                reads <= reads + CNT_W'(1);
            if (inc_wr && !(&writes))
                writes <= writes + CNT_W'(1);
            if (inc_hit && !(&hits))
                hits <= hits + CNT_W'(1);
            if (inc_miss && !(&misses))
                misses <= misses + CNT_W'(1);
            if (hit_sat)
                sat <= 1'b1;
        end
    end

`ifdef LLC_STATS_RATIO_EN
    // state | meaning
    // IDLE  | waiting for ratio_req
    // LOAD  | snapshot N = hits*10000 and D = hits+misses
    // DIV   | restoring division, one quotient bit per cycle
    // DONE  | ratio_pct published, ratio_valid high for this cycle
    localparam int QW = CNT_W + 14;
    localparam int DW = CNT_W + 1;
    localparam int BW = $clog2(QW);
    localparam logic [QW-1:0] SCALE    = QW'(10000);
    localparam logic [BW-1:0] LAST_BIT = BW'(QW - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} div_state_t;

    div_state_t    state;
    logic [QW-1:0] quo;
    logic [DW-1:0] den;
    logic [DW-1:0] rem;
    logic [BW-1:0] bit_cnt;
    logic [QW-1:0] n_load;
    logic [DW-1:0] d_load;
    logic [DW:0]   rem_sh;
    logic [DW-1:0] rem_sub;
    logic          take;

    // quo doubles as the dividend shift register: numerator bits leave at the top
    // while quotient bits enter at the bottom.
    always_comb begin
        n_load  = QW'(hits) * SCALE;
        d_load  = DW'(hits) + DW'(misses);
        rem_sh  = {rem, quo[QW-1]};
        take    = (rem_sh >= {1'b0, den});
        rem_sub = DW'(rem_sh - {1'b0, den});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            quo         <= '0;
            den         <= '0;
            rem         <= '0;
            bit_cnt     <= '0;
            ratio_busy  <= 1'b0;
            ratio_valid <= 1'b0;
            ratio_pct   <= '0;
        end else if (clr) begin
            state       <= IDLE;
            ratio_busy  <= 1'b0;
            ratio_valid <= 1'b0;
            ratio_pct   <= '0;
        end else begin
            ratio_valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (ratio_req) begin
                        state      <= LOAD;
                        ratio_busy <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                LOAD: begin
                    quo     <= n_load;
                    den     <= d_load;
                    rem     <= '0;
                    bit_cnt <= LAST_BIT;
                    if (d_load == '0) begin
                        state       <= DONE;
                        ratio_busy  <= 1'b0;
                        ratio_valid <= 1'b1;
                        ratio_pct   <= '0;
                    end else begin
                        state <= DIV;
                    end
                end
                DIV: begin
                    quo <= {quo[QW-2:0], take};
                    rem <= take ? rem_sub : rem_sh[DW-1:0];
                    if (bit_cnt == '0) begin
                        state       <= DONE;
                        ratio_busy  <= 1'b0;
                        ratio_valid <= 1'b1;
                        ratio_pct   <= {quo[12:0], take};
                    end else begin
                        bit_cnt <= bit_cnt - BW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    // Without the divider a request is simply acknowledged on the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ratio_valid <= 1'b0;
        else
            ratio_valid <= ratio_req && !clr;
    end

    assign ratio_busy = 1'b0;
    assign ratio_pct  = '0;
`endif

endmodule
